// File: rtl/imem_pkg.sv
// +----------------------------------------------------------------------+
// | imem_pkg : shared types and constants for the instruction loader.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package imem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;
endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// +----------------------------------------------------------------------+
// | imem_loader_if : byte stream (valid/ready) into the program loader.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/imem_byte_ram.sv
// +----------------------------------------------------------------------+
// | imem_byte_ram : byte-wide program store, cleared on reset, with a    |
// | combinational little-endian word read port (out of range -> 0).      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int N_WORDS = 12,
    parameter int IW      = 30,
    parameter int BAW     = $clog2(N_WORDS * WORD_BYTES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [BAW-1:0] waddr,
    input  logic [7:0]     wdata,
    input  logic [IW-1:0]  ridx,
    output word_t          rdata
);
    localparam int            c_NB      = N_WORDS * WORD_BYTES;
    localparam logic [IW-1:0] c_N_WORDS = IW'(N_WORDS);

    logic [7:0] r_mem [c_NB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NB; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reads see the stored value, so a same-cycle write shows up one cycle later.
    always_comb begin
        rdata = '0;
        if (ridx < c_N_WORDS) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                rdata[8*b +: 8] = r_mem[{ridx[BAW-3:0], 2'(b)}];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------+
// | imem_loader : streams program bytes into instruction memory, holds   |
// | the core until loaded. Option: IMEM_LOADER_CHECKSUM_EN (XOR check).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int N_WORDS = 12,
    parameter int AW      = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    imem_loader_if.slave                        s,
    input  logic [AW-1:0]                       fetch_addr,
    output word_t                               instr,
    output logic                                cpu_hold,
    output logic                                done,
    output logic [$clog2(4*N_WORDS+1)-1:0]      byte_cnt,
    output logic                                err
);
    localparam int              c_NB   = N_WORDS * WORD_BYTES;
    localparam int              c_CW   = $clog2(c_NB + 1);
    localparam int              c_BAW  = $clog2(c_NB);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NB - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(c_NB);

    ld_state_t       r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt,   w_cnt_nxt;
    logic            w_we;
    logic            w_ready;
    logic            w_unused_lsb;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic            r_err, w_err_nxt;
    logic [7:0]      r_xor, w_xor_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_ready     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_err_nxt   = r_err;
        w_xor_nxt   = r_xor;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_err_nxt   = 1'b0;
                    w_xor_nxt   = '0;
`endif
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (s.s_valid) begin
                    w_we = 1'b1;
                    if (r_cnt != c_FULL) begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_xor_nxt = r_xor ^ s.s_data;
                    if (r_cnt == c_LAST) w_state_nxt = CHECK;
`else
                    if (r_cnt == c_LAST) w_state_nxt = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                w_ready = 1'b1;
                if (s.s_valid) begin
                    if (s.s_data == r_xor) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_err   <= 1'b0;
            r_xor   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_err   <= w_err_nxt;
            r_xor   <= w_xor_nxt;
`endif
        end
    end

    assign s.s_ready = w_ready;
    assign byte_cnt  = r_cnt;
    assign done      = (r_state == DONE);
    assign cpu_hold  = (r_state != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

    // Byte offset within the fetched word has no meaning for a word fetch.
    assign w_unused_lsb = ^fetch_addr[1:0];

    imem_byte_ram #(
        .N_WORDS (N_WORDS),
        .IW      (AW - 2),
        .BAW     (c_BAW)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (w_we),
        .waddr (r_cnt[c_BAW-1:0]),
        .wdata (s.s_data),
        .ridx  (fetch_addr[AW-1:2]),
        .rdata (instr)
    );
endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------+
// | tb_imem_loader : randomized self-checking bench for imem_loader.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;
    import imem_pkg::*;

    localparam int N_WORDS = 12;
    localparam int AW      = 32;
    localparam int NB      = 4 * N_WORDS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] fetch_addr;
    word_t         instr;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [5:0]    byte_cnt;

    imem_loader_if bus ();

    imem_loader #(.N_WORDS(N_WORDS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s          (bus.slave),
        .fetch_addr (fetch_addr),
        .instr      (instr),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .byte_cnt   (byte_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference model: byte image of memory plus accepted-byte count.
    logic [7:0] m_mem [NB];
    int         m_cnt;
    word_t      prog  [N_WORDS];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t ref_fetch(input logic [31:0] a);
        int k;
        if (a[31:2] >= 30'(N_WORDS)) return '0;
        k = int'(a[31:2]);
        return {m_mem[4*k+3], m_mem[4*k+2], m_mem[4*k+1], m_mem[4*k]};
    endfunction

    function automatic logic [7:0] prog_byte(input int i);
        word_t w;
        w = prog[i/4];
        return w[8*(i%4) +: 8];
    endfunction

    task automatic check_fetch(input string tag, input logic [31:0] a);
        fetch_addr = a;
        #1;
        check(tag, instr, ref_fetch(a));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_cnt = 0;
    endtask

    // Offers one byte until accepted; optionally with random valid gaps.
    task automatic send(input logic [7:0] d, input bit gaps, input bit is_prog);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            bus.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_data  = d;
            if (is_prog) fetch_addr = 32'(m_cnt / 4) << 2;
            @(negedge clk);
            check("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
            check("s_ready", 32'(bus.s_ready), 32'd1);
            check("hold_loading", 32'(cpu_hold), 32'd1);
            if (is_prog) check("fetch_during_write", instr, ref_fetch(fetch_addr));
            acc = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check("accepted", 32'(acc), 32'd1);
        if (acc && is_prog) begin
            m_mem[m_cnt] = d;
            m_cnt++;
        end
    endtask

    task automatic load_bytes(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) send(prog_byte(i), gaps, 1'b1);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < NB; i++) x ^= m_mem[i];
        send(x, 1'b0, 1'b0);
`endif
        check("done", 32'(done), 32'd1);
        check("hold_done", 32'(cpu_hold), 32'd0);
        check("ready_done", 32'(bus.s_ready), 32'd0);
        check("err_done", 32'(err), 32'd0);
        check("cnt_done", 32'(byte_cnt), 32'(NB));
    endtask

    // Extra byte offered after completion must be refused.
    task automatic over_send();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        @(negedge clk);
        check("ready_byte49", 32'(bus.s_ready), 32'd0);
        check("cnt_sat", 32'(byte_cnt), 32'(NB));
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        for (int k = 0; k < N_WORDS; k++) check_fetch("mem_after_extra", 32'(4 * k));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        prog = '{32'h80010028, 32'h80020014, 32'h00221820, 32'hAC030030,
                 32'h8C040030, 32'h00832022, 32'h10800002, 32'h00000000,
                 32'h08000000, 32'h3C05ABCD, 32'h34A51234, 32'h1282FFFD};
        for (int i = 0; i < NB; i++) m_mem[i] = '0;
        m_cnt       = 0;
        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        fetch_addr  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, no start
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(bus.s_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(byte_cnt), 32'd0);
        check_fetch("rst_fetch0", 32'h0);

        // Full load, no gaps
        do_start();
        load_bytes(0, NB, 1'b0);
        finish_load();
        check_fetch("fetch_00", 32'h00);
        check("word0_lit", instr, 32'h80010028);
        check_fetch("fetch_2c", 32'h2C);
        check("word11_lit", instr, 32'h1282FFFD);
        check_fetch("fetch_2e", 32'h2E);
        check("word11_unaligned", instr, 32'h1282FFFD);
        check_fetch("fetch_30", 32'h30);
        check("beyond_lit", instr, 32'h0);
        over_send();

        // Full load with random gaps and an ignored mid-load start
        do_start();
        load_bytes(0, 10, 1'b1);
        start = 1'b1;
        @(negedge clk);
        check("start_in_load", 32'(byte_cnt), 32'(m_cnt));
        @(posedge clk); #1;
        start = 1'b0;
        load_bytes(10, NB - 10, 1'b1);
        finish_load();
        for (int k = 0; k < N_WORDS; k++) begin
            check_fetch("gap_word", 32'(4 * k));
            check("gap_word_lit", instr, prog[k]);
        end
        over_send();

        // Reset mid-load
        do_start();
        load_bytes(0, 20, 1'b1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < NB; i++) m_mem[i] = '0;
        m_cnt = 0;
        check("midrst_cnt", 32'(byte_cnt), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_ready", 32'(bus.s_ready), 32'd0);
        for (int k = 0; k <= N_WORDS; k++) check_fetch("midrst_fetch", 32'(4 * k));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_start();
        load_bytes(0, NB, 1'b1);
        finish_load();

        // Partial reload of word 0
        do_start();
        send(8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b1);
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check_fetch("reload_w0", 32'h0);
        check("reload_w0_lit", instr, 32'h00000020);
        check_fetch("reload_w1", 32'h4);
        check("reload_w1_lit", instr, 32'h80020014);
        load_bytes(4, NB - 4, 1'b0);
        finish_load();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        do_start();
        load_bytes(0, NB, 1'b1);
        begin
            logic [7:0] x;
            x = '0;
            for (int i = 0; i < NB; i++) x ^= m_mem[i];
            send(x ^ 8'h5A, 1'b0, 1'b0);
        end
        check("bad_err", 32'(err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_ready", 32'(bus.s_ready), 32'd0);
        do_start();
        check("err_cleared", 32'(err), 32'd0);
        load_bytes(0, NB, 1'b0);
        finish_load();
`endif

        // Random program and random fetch addresses
        do_start();
        for (int i = 0; i < NB; i++) send(8'($urandom), 1'b1, 1'b1);
        finish_load();
        for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) check_fetch("rand_fetch_lo", 32'($urandom_range(0, 63)));
            else            check_fetch("rand_fetch_any", $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
